// File: rtl/micro_seq_pkg.sv
// Shared control-unit definitions: phase encoding, micro-address defaults,
// dispatch base and microword field positions used by the control store.
package micro_seq_pkg;

    localparam int UA_W_DEF     = 6;
    localparam int FETCH_UA_DEF = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4
    } phase_t;

    // Microword bit positions, common to this sequencer and the control store.
    localparam int MW_HALT_BIT    = 0;
    localparam int MW_BR_OP_BIT   = 1;
    localparam int MW_NEXT_UA_LSB = 2;

    function automatic int dispatch_base(input int ua_w);
        return 1 << (ua_w - 1);
    endfunction

endpackage

// File: rtl/micro_seq_phase_ring.sv
// IDLE/T1-T4 beat generator. All outputs are registered and decoded from the
// state being entered, so each C pulse is exactly one clock wide.
module micro_seq_phase_ring
    import micro_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    output logic C1,
    output logic C2,
    output logic C3,
    output logic C4,
    output logic running,
    output logic cyc_end
);

    phase_t state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            C1      <= 1'b0;
            C2      <= 1'b0;
            C3      <= 1'b0;
            C4      <= 1'b0;
            running <= 1'b0;
            cyc_end <= 1'b0;
        end else begin
            C1      <= 1'b0;
            C2      <= 1'b0;
            C3      <= 1'b0;
            C4      <= 1'b0;
            cyc_end <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_T1;
                        C1      <= 1'b1;
                        running <= 1'b1;
                    end
                end
                ST_T1: begin
                    state <= ST_T2;
                    C2    <= 1'b1;
                end
                ST_T2: begin
                    state <= ST_T3;
                    C3    <= 1'b1;
                end
                ST_T3: begin
                    state   <= ST_T4;
                    C4      <= 1'b1;
                    cyc_end <= 1'b1;
                end
                ST_T4: begin
                    // T4 -> T1 is a single edge, so back-to-back cycles have no bubble.
                    if (stop) begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end else begin
                        state <= ST_T1;
                        C1    <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/micro_seq.sv
// Microprogram sequencer: four-phase beat generation, uAR next-address
// selection (next-address field or opcode dispatch) and micro-cycle counter.
module micro_seq
    import micro_seq_pkg::*;
#(
    parameter int UA_W     = UA_W_DEF,
    parameter int FETCH_UA = FETCH_UA_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic            halt,
    input  logic            br_op,
    input  logic [UA_W-1:0] next_ua,
    input  logic [7:0]      opcode,
    output logic            C1,
    output logic            C2,
    output logic            C3,
    output logic            C4,
    output logic [UA_W-1:0] ua,
    output logic            running,
    output logic [15:0]     ucycles
);

    localparam logic [UA_W-1:0] DISP_BASE  = UA_W'(dispatch_base(UA_W));
    localparam logic [UA_W-1:0] RESET_UA   = UA_W'(FETCH_UA);

    logic            cyc_end;
    logic [UA_W-1:0] dispatch_ua;
    logic            unused_opcode_lo;

    // Only the high nibble selects the dispatch target; the low nibble is an operand.
    assign dispatch_ua      = DISP_BASE | {{(UA_W-4){1'b0}}, opcode[7:4]};
    assign unused_opcode_lo = ^opcode[3:0];

    micro_seq_phase_ring phase_ring (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (halt | step),
        .C1      (C1),
        .C2      (C2),
        .C3      (C3),
        .C4      (C4),
        .running (running),
        .cyc_end (cyc_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ua      <= RESET_UA;
            ucycles <= 16'd0;
        end else if (cyc_end) begin
            ua      <= br_op ? dispatch_ua : next_ua;
            ucycles <= ucycles + 16'd1;
        end
    end

endmodule

// File: doc/micro_seq.md
# micro_seq

Four-phase timing generator and microprogram sequencer for the model CPU control unit. It generates the C1–C4 beat pulses, including the C4 load strobe consumed by the instruction register. It holds the micro-address register (uAR) that indexes the control store. At the end of each micro-cycle it picks the next micro-address, either from the control-store next-address field or by dispatching on the 8-bit opcode returned from the instruction register.

## Interface
- `UA_W`, default 6: micro-address width, minimum 5.
- `FETCH_UA`, default 0: reset / fetch micro-address.
- `clk  in  1`: system clock. All state changes on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `start  in  1`: level. Begins running from IDLE.
- `step  in  1`: level. While high, the sequencer returns to IDLE after every completed micro-cycle.
- `halt  in  1`: halt bit of the current microword. Sampled in T4.
- `br_op  in  1`: microword "dispatch on opcode" bit. Sampled in T4.
- `next_ua  in  UA_W`: microword next-address field. Sampled in T4.
- `opcode  in  8`: registered opcode from the instruction register. Sampled in T4.
- `C1`, `C2`, `C3`, `C4  out  1`: one-hot beat pulses, each exactly one clk cycle wide.
- `ua  out  UA_W`: current micro-address (uAR).
- `running  out  1`: high in T1–T4.
- `ucycles  out  16`: count of completed micro-cycles. Wraps.

## Operation
- States: IDLE, T1, T2, T3, T4. Encode one-hot or binary; either is acceptable.
- In T*n*, exactly Cn is high. In IDLE all C outputs are low.
- IDLE → T1 when `start`=1. Otherwise remain in IDLE.
- T1 → T2 → T3 → T4 unconditionally.
- From T4:
  - → IDLE if `halt`=1 or `step`=1.
  - Otherwise → T1.
- uAR update occurs only on the T4 → any edge:
  - If `br_op`=1: `ua` ← (1 << (UA_W−1)) | opcode[7:4], zero-extended. With UA_W=6 this is 32 + opcode[7:4].
  - Else: `ua` ← `next_ua`.
  - The update happens even when leaving to IDLE. After a halt, `ua` points at the successor microword.
- `halt` and `br_op` both 1 in T4: the dispatch address is loaded, then the sequencer goes to IDLE.
- `ucycles` increments by 1 on every T4 → any edge and wraps from 0xFFFF to 0.
- `start` while not in IDLE is ignored. `start` held high with `step`=1 runs one micro-cycle, returns to IDLE, then immediately restarts in the following cycle.
- `opcode`, `next_ua`, `halt`, `br_op` are don't-care outside T4.

## Timing
- Reset values (`rst` low, asynchronous): state IDLE, C1–C4 = 0, `ua` = FETCH_UA, `running` = 0, `ucycles` = 0.
- Reset asserted mid-cycle (any of T1–T4) aborts immediately. No partial uAR update. Outputs take the reset values without waiting for a clock edge.
- All outputs are registered; no combinational input-to-output paths.
- `start` sampled high at edge k → C1 high in cycle k+1, C4 high in cycle k+4. The new `ua` is visible in cycle k+5, the same cycle as the next C1 when continuing.
- The IR samples on the falling edge while C4 is high. The opcode it captures is visible to this block only in the next micro-cycle's T4. Microcode must therefore place the fetch (C4 load) one microword before any `br_op` dispatch.
- Back-to-back micro-cycles have no bubble: T4 → T1 is a single edge.

## Structure
- Shared control-unit package holds:
  - Phase state encoding constants (ST_IDLE, ST_T1..ST_T4).
  - UA_W default and FETCH_UA.
  - The dispatch base constant (1 << (UA_W−1)).
  - The microword field bit positions for `halt`, `br_op`, `next_ua`, which are shared with the control-store module.
- One natural sub-module: `phase_ring`. It holds the IDLE/T1–T4 state machine and C1–C4 decode, with inputs `start`, `stop` (= halt|step) and output `cyc_end` (T4).
- The uAR mux and `ucycles` counter stay in `micro_seq`.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, then release with `start`=0 → C1–C4 = 0, `ua`=0, `running`=0, `ucycles`=0 for 10 cycles.
- **Free run:** `start`=1 for one cycle; `next_ua` follows `ua`+1 and `halt`=`br_op`=0. Required response:
  - C pattern 1000, 0100, 0010, 0001 repeats with no gaps.
  - `ua` steps 0, 1, 2, 3 at each T1.
  - `ucycles`=3 after 12 phase cycles.
- **Dispatch:** `opcode`=8'hA7, `br_op`=1 in T4 → `ua`=6'd42 (32+10) at the next T1. `next_ua` is ignored.
- **Halt with dispatch:** `halt`=1 and `br_op`=1, `opcode`=8'h30, in T4 → IDLE next cycle, `ua`=35, `running`=0. A later `start` resumes at `ua`=35.
- **Step mode:** `step`=1 and `start` pulsed three times, 10 cycles apart → exactly three micro-cycles, each returning to IDLE after T4; `ucycles`=3.
- **Async reset mid-cycle:** assert `rst` low between edges during T2 with `ua`=5 → outputs go to reset values before the next clock edge; `ua`=0 with no update from that T4.
